freq_gen: RTL

Multi-channel programmable clock/tick generator for the 50 MHz system clock. It is the parametrised successor to the fixed 1 kHz divider and feeds the calculator's scan, debounce and blink logic. Each of CH channels produces a 50 % duty divided clock and a single-cycle tick on that clock's rising transition. Each channel's divisor can be reloaded at run time through a valid/ready port, and the new value takes effect glitch-free at the channel's next terminal count.

---
 rtl/freq_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/freq_gen.sv
// Multi-channel programmable divided-clock and tick generator with run-time divisor reload.
// Define FREQ_GEN_TICK_EN to build the per-channel tick registers; otherwise tick is tied to 0.
module freq_gen #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned CH           = 4,
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = CLK_HZ / 1000 / 2 - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]        cfg_half,
  input  logic                    sync_clr,
  output logic [CH-1:0]           clk_out,
  output logic [CH-1:0]           tick
);

  localparam int unsigned CHW = $clog2(CH);
  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e           state_q;
  logic             ready_q;
  logic [CHW-1:0]   ch_q;
  logic [CNT_W-1:0] shadow_q;

  logic [CNT_W-1:0] cnt_q  [CH];
  logic [CNT_W-1:0] half_q [CH];
  logic [CNT_W-1:0] half_d [CH];
  logic [CH-1:0]    clk_out_q;
  logic [CH-1:0]    term;

  logic handshake;
  logic cfgInRange;

  assign handshake  = cfg_valid && ready_q;
  assign cfgInRange = (32'(cfg_ch) < CH);

  // A pending divisor lands on its channel's terminal count (or at once on sync_clr);
  // a handshake coinciding with sync_clr bypasses the shadow and lands immediately.
  always_comb begin
    term = '0;
    for (int i = 0; i < CH; i++) begin
      term[i]   = cnt_q[i] >= half_q[i];
      half_d[i] = half_q[i];
      if (state_q == PEND && ch_q == CHW'(i) && (term[i] || sync_clr))
        half_d[i] = shadow_q;
      else if (sync_clr && handshake && cfgInRange && cfg_ch == CHW'(i))
        half_d[i] = cfg_half;
    end
  end

  // The toggle in the load cycle is decided by the old half_q, so there is no runt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= '0;
        half_q[i] <= RESET_HALF;
      end
      clk_out_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        half_q[i] <= half_d[i];
        if (sync_clr) begin
          cnt_q[i]     <= '0;
          clk_out_q[i] <= 1'b0;
        end else if (term[i]) begin
          cnt_q[i]     <= '0;
          clk_out_q[i] <= ~clk_out_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      ch_q     <= '0;
      shadow_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake && cfgInRange && !sync_clr) begin
            ch_q     <= cfg_ch;
            shadow_q <= cfg_half;
            state_q  <= PEND;
            ready_q  <= 1'b0;
          end
        end
        PEND: begin
          if (term[ch_q] || sync_clr) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign clk_out   = clk_out_q;

`ifdef FREQ_GEN_TICK_EN
  logic [CH-1:0] tick_q;

  // Registered alongside clk_out so the pulse coincides with the first high cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_q <= '0;
    else if (sync_clr)
      tick_q <= '0;
    else
      tick_q <= term & ~clk_out_q;
  end

  assign tick = tick_q;
`else
  assign tick = '0;
`endif

endmodule
